// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush controller with hazard statistics
// Resolves load-use, taken-branch and data-memory-wait hazards for the 5-stage core.
module hazard_control_unit #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_rs1_used,
  input  logic             if_id_rs2_used,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             branch_taken,
  input  logic             ex_mem_mem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] load_use_stalls,
  output logic [CNT_W-1:0] freeze_cycles,
  output logic [CNT_W-1:0] branch_flushes,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  // The flag is registered, so it is armed one count early to land with the counter reaching TIMEOUT-1.
  localparam logic [WAIT_W-1:0] WAIT_SET = WAIT_W'(TIMEOUT - 2);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              load_use;

  assign freeze   = ex_mem_mem_req & ~dmem_ack;
  assign load_use = id_ex_mem_read & (id_ex_rd != 5'd0) &
                    ((if_id_rs1_used & (id_ex_rd == if_id_rs1)) |
                     (if_id_rs2_used & (id_ex_rd == if_id_rs2)));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (reset) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RUN;
      wait_cnt        <= '0;
      mem_timeout     <= 1'b0;
      load_use_stalls <= '0;
      freeze_cycles   <= '0;
      branch_flushes  <= '0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (freeze) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (freeze) begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt >= WAIT_SET) mem_timeout <= 1'b1;
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
      endcase

      if (freeze && (freeze_cycles != '1))
        freeze_cycles <= freeze_cycles + CNT_W'(1);
      if (!freeze && branch_taken && (branch_flushes != '1))
        branch_flushes <= branch_flushes + CNT_W'(1);
      if (!freeze && !branch_taken && load_use && (load_use_stalls != '1))
        load_use_stalls <= load_use_stalls + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline stall/flush controller for the 5-stage RISC-V core; the stalling counterpart to operand forwarding. It handles what forwarding cannot resolve: load-use hazards (one bubble), taken-branch redirects (squash IF/ID and ID/EX), and multi-cycle data-memory accesses (freeze the whole pipeline until acknowledged). It sits beside the ID stage and drives the write-enable and flush controls of the PC and all pipeline registers. It also keeps saturating hazard statistics and a sticky memory-timeout flag.

## Interface
- CNT_W, 16, width of each statistics counter
- TIMEOUT, 64, consecutive memory-wait cycles that set mem_timeout (≥2)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID
- if_id_rs1_used, if_id_rs2_used  in  1 each  instruction in ID actually reads that source
- id_ex_rd  in  5  destination of the instruction in EX
- id_ex_mem_read  in  1  instruction in EX is a load
- branch_taken  in  1  EX resolved a taken branch or jump this cycle
- ex_mem_mem_req  in  1  instruction in MEM needs data memory
- dmem_ack  in  1  data memory completes the access this cycle
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  register load enables
- if_id_flush, id_ex_flush  out  1 each  replace register contents with a NOP bubble
- mem_wb_bubble  out  1  load a bubble into MEM/WB
- load_use_stalls, freeze_cycles, branch_flushes  out  CNT_W each  saturating statistics
- mem_timeout  out  1  sticky memory-timeout flag

## Operation
- Hazard terms (combinational):
  - freeze = ex_mem_mem_req & ~dmem_ack
  - load_use = id_ex_mem_read & id_ex_rd≠0 & ((if_id_rs1_used & id_ex_rd==if_id_rs1) | (if_id_rs2_used & id_ex_rd==if_id_rs2))
- Control outputs, strict priority; the first matching case wins:
  - reset high: all write enables 1; if_id_flush, id_ex_flush, mem_wb_bubble all 1 (drains the pipe).
  - freeze: pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_bubble = 1; both flushes 0. branch_taken and load_use are ignored, because EX is held and re-presents them after the freeze.
  - branch_taken: all write enables 1; if_id_flush = id_ex_flush = 1. load_use is ignored because the dependent instruction is squashed.
  - load_use: pc_write = if_id_write = 0; id_ex_flush = 1; id_ex_write, ex_mem_write = 1.
  - otherwise: all write enables 1; flushes and bubble 0.
- FSM states:
  - RUN: go to MEM_WAIT when freeze = 1.
  - MEM_WAIT: stay while freeze = 1; return to RUN on the first cycle with freeze = 0.
  - The outputs above do not depend on state. State drives only the wait counter and statistics.
- Wait counter: cleared in RUN; increments each cycle spent in MEM_WAIT with freeze = 1, saturating at TIMEOUT. mem_timeout sets when the counter reaches TIMEOUT−1 while freeze is still 1. It then stays set until reset; the freeze itself continues.
- Statistics (saturating at 2^CNT_W−1, never wrap):
  - load_use_stalls: +1 per cycle the load_use case wins.
  - freeze_cycles: +1 per freeze cycle.
  - branch_flushes: +1 per cycle the branch case wins.

## Timing
- All control outputs are combinational, same cycle as their inputs. Hazard detection must complete before the pipeline-register edge.
- Load-use costs exactly one bubble. On the next cycle the load has moved to MEM and id_ex_mem_read now describes the bubble, so load_use drops without extra state.
- Back-to-back events:
  - A freeze arriving during a load-use cycle takes priority; the stall resumes after dmem_ack.
  - dmem_ack in the first request cycle produces no freeze and no state change.
- Counter and state updates are visible one cycle after the qualifying cycle.
- Reset mid-MEM_WAIT:
  - Next cycle: state RUN, counters 0, mem_timeout 0.
  - Outputs follow the reset row while reset is high.
- Reset values: state RUN, wait counter 0, load_use_stalls = freeze_cycles = branch_flushes = 0, mem_timeout = 0.

## Test plan
- Load x5 in EX (id_ex_rd=5, id_ex_mem_read=1), ID reads rs1=5 with rs1_used=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; next cycle normal; load_use_stalls=1.
- Same as above but rd=0, or rs1_used=0 -> no stall; counter stays 0.
- ex_mem_mem_req=1, dmem_ack low for 3 cycles then high -> 3 cycles with all four enables 0 and mem_wb_bubble=1; freeze_cycles=3; state RUN after the ack.
- branch_taken=1 together with load_use=1 -> flushes both 1, pc_write=1, no stall; branch_flushes=1, load_use_stalls=0. Then branch_taken during a freeze -> freeze wins and branch_flushes is unchanged.
- TIMEOUT=4, dmem_ack held low -> mem_timeout rises on the 4th freeze cycle and stays 1 after the ack arrives. A reset pulse clears it and all counters.
- CNT_W=2, five load-use stalls -> load_use_stalls saturates at 3.
